// File: rtl/pulse_width_meter.sv
// pulse_width_meter
// Measures the high-time of a sampled signal in clock cycles, driven by the
// single-cycle rise/fall pulses of an upstream edge detector. Each completed
// pulse produces one result in a one-entry output register with a
// valid/ready handshake. The counter saturates at all-ones and flags the
// saturation. A result that finds the output register occupied is dropped
// and reported with a one-cycle drop pulse.
// All outputs come straight from flops, so no input reaches an output
// combinationally.

module pulse_width_meter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             rising_edge_i,
  input  logic             falling_edge_i,
  output logic [CNT_W-1:0] width_o,
  output logic             overflow_o,
  output logic             width_valid_o,
  input  logic             width_ready_i,
  output logic             drop_o
);

  typedef enum logic {
    IDLE    = 1'b0,
    MEASURE = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  state_t           r_state;
  state_t           w_next_state;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_next_cnt;
  logic             r_sat;
  logic             w_next_sat;
  logic             w_capture;

  logic [CNT_W-1:0] r_width;
  logic             r_overflow;
  logic             r_valid;
  logic             r_drop;

  logic             w_accept;
  logic             w_load;
  logic             w_drop;

  // Measurement state, counter and saturation flag registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_sat   <= 1'b0;
    end else begin
      r_state <= w_next_state;
      r_cnt   <= w_next_cnt;
      r_sat   <= w_next_sat;
    end
  end

  // Next-state logic: start on rise, count while high, capture on fall
  always_comb begin
    w_next_state = r_state;
    w_next_cnt   = r_cnt;
    w_next_sat   = r_sat;
    w_capture    = 1'b0;
    case (r_state)
      IDLE: begin
        if (rising_edge_i) begin
          w_next_state = MEASURE;
          w_next_cnt   = CNT_ONE;
          w_next_sat   = 1'b0;
        end
      end
      MEASURE: begin
        if (falling_edge_i) begin
          w_capture    = 1'b1;
          w_next_state = IDLE;
        end else if (rising_edge_i) begin
          w_next_cnt = CNT_ONE;
          w_next_sat = 1'b0;
        end else if (r_cnt == CNT_MAX) begin
          w_next_sat = 1'b1;
        end else begin
          w_next_cnt = r_cnt + CNT_ONE;
        end
      end
      default: begin
        w_next_state = IDLE;
      end
    endcase
  end

  // Handshake decode: load when the slot is free or being emptied this cycle
  always_comb begin
    w_accept = r_valid & width_ready_i;
    w_load   = w_capture & (~r_valid | width_ready_i);
    w_drop   = w_capture & r_valid & ~width_ready_i;
  end

  // One-entry output register with valid flag and registered drop pulse
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_width    <= '0;
      r_overflow <= 1'b0;
      r_valid    <= 1'b0;
      r_drop     <= 1'b0;
    end else begin
      r_drop <= w_drop;
      if (w_load) begin
        r_width    <= r_cnt;
        r_overflow <= r_sat;
        r_valid    <= 1'b1;
      end else if (w_accept) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign width_o       = r_width;
  assign overflow_o    = r_overflow;
  assign width_valid_o = r_valid;
  assign drop_o        = r_drop;

endmodule

// File: tb/tb_pulse_width_meter.sv
// tb_pulse_width_meter
// Directed test of pulse_width_meter. Two instances share all inputs: one at
// the default 16-bit counter width and one at 4 bits so saturation is reached
// quickly. Inputs change 1 ns after each rising edge and outputs are sampled
// at that same point, so every check sees the state left by the last edge.

module tb_pulse_width_meter;

  logic        clk;
  logic        reset;
  logic        rise;
  logic        fall;
  logic        ready;

  logic [15:0] width16;
  logic        ovf16;
  logic        valid16;
  logic        drop16;

  logic [3:0]  width4;
  logic        ovf4;
  logic        valid4;
  logic        drop4;

  int checkCount;
  int failCount;

  pulse_width_meter #(.CNT_W(16)) dut16 (
    .clk            (clk),
    .reset          (reset),
    .rising_edge_i  (rise),
    .falling_edge_i (fall),
    .width_o        (width16),
    .overflow_o     (ovf16),
    .width_valid_o  (valid16),
    .width_ready_i  (ready),
    .drop_o         (drop16)
  );

  pulse_width_meter #(.CNT_W(4)) dut4 (
    .clk            (clk),
    .reset          (reset),
    .rising_edge_i  (rise),
    .falling_edge_i (fall),
    .width_o        (width4),
    .overflow_o     (ovf4),
    .width_valid_o  (valid4),
    .width_ready_i  (ready),
    .drop_o         (drop4)
  );

  // 10 ns free-running clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Compare one observed value against its expected value and log a mismatch
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
    end
  endtask

  // Drive one cycle of inputs and advance to 1 ns after the sampling edge
  task automatic applyStimulus(input logic r, input logic f, input logic rdy);
    rise  = r;
    fall  = f;
    ready = rdy;
    @(posedge clk);
    #1;
    rise = 1'b0;
    fall = 1'b0;
  endtask

  // A rise pulse followed k cycles later by a fall pulse (width k, k >= 2)
  task automatic runPulse(input int k, input logic rdy);
    applyStimulus(1'b1, 1'b0, rdy);
    for (int i = 0; i < k - 1; i++) applyStimulus(1'b0, 1'b0, rdy);
    applyStimulus(1'b0, 1'b1, rdy);
  endtask

  // Test sequence
  initial begin
    checkCount = 0;
    failCount  = 0;
    rise  = 1'b0;
    fall  = 1'b0;
    ready = 1'b1;
    reset = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_valid", {31'd0, valid16}, 32'd0);
    checkOutput("rst_width", {16'd0, width16}, 32'd0);
    checkOutput("rst_ovf",   {31'd0, ovf16},   32'd0);
    checkOutput("rst_drop",  {31'd0, drop16},  32'd0);
    reset = 1'b1;

    // Basic width 7: rise, 6 quiet cycles, fall
    applyStimulus(1'b0, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b1);
    applyStimulus(1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 6; i++) applyStimulus(1'b0, 1'b0, 1'b1);
    checkOutput("w7_pre_valid", {31'd0, valid16}, 32'd0);
    applyStimulus(1'b0, 1'b1, 1'b1);
    checkOutput("w7_valid", {31'd0, valid16}, 32'd1);
    checkOutput("w7_width", {16'd0, width16}, 32'd7);
    checkOutput("w7_ovf",   {31'd0, ovf16},   32'd0);
    checkOutput("w7_width4", {28'd0, width4}, 32'd7);
    applyStimulus(1'b0, 1'b0, 1'b1);
    checkOutput("w7_post_valid", {31'd0, valid16}, 32'd0);
    checkOutput("w7_post_width", {16'd0, width16}, 32'd7);

    // Saturation boundary on the 4-bit instance: 15 fits, 16 saturates
    runPulse(15, 1'b1);
    checkOutput("b15_width4", {28'd0, width4}, 32'd15);
    checkOutput("b15_ovf4",   {31'd0, ovf4},   32'd0);
    applyStimulus(1'b0, 1'b0, 1'b1);
    runPulse(16, 1'b1);
    checkOutput("b16_width4", {28'd0, width4}, 32'd15);
    checkOutput("b16_ovf4",   {31'd0, ovf4},   32'd1);
    checkOutput("b16_width16", {16'd0, width16}, 32'd16);
    applyStimulus(1'b0, 1'b0, 1'b1);

    // Width 20: saturated on 4 bits, exact on 16 bits
    runPulse(20, 1'b1);
    checkOutput("s20_width4",  {28'd0, width4},  32'd15);
    checkOutput("s20_ovf4",    {31'd0, ovf4},    32'd1);
    checkOutput("s20_width16", {16'd0, width16}, 32'd20);
    checkOutput("s20_ovf16",   {31'd0, ovf16},   32'd0);
    // Rise immediately after the fall starts a 5-cycle pulse
    applyStimulus(1'b1, 1'b0, 1'b1);
    checkOutput("s5_gap_valid", {31'd0, valid4}, 32'd0);
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b1, 1'b1);
    checkOutput("s5_width4", {28'd0, width4}, 32'd5);
    checkOutput("s5_ovf4",   {31'd0, ovf4},   32'd0);
    applyStimulus(1'b0, 1'b0, 1'b1);

    // Back-pressure: width 5 held, width 3 dropped
    runPulse(5, 1'b0);
    checkOutput("bp_valid5", {31'd0, valid16}, 32'd1);
    checkOutput("bp_width5", {16'd0, width16}, 32'd5);
    checkOutput("bp_nodrop", {31'd0, drop16},  32'd0);
    applyStimulus(1'b0, 1'b0, 1'b0);
    runPulse(3, 1'b0);
    checkOutput("bp_drop",      {31'd0, drop16},  32'd1);
    checkOutput("bp_drop4",     {31'd0, drop4},   32'd1);
    checkOutput("bp_hold_width", {16'd0, width16}, 32'd5);
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("bp_drop_end", {31'd0, drop16},  32'd0);
    checkOutput("bp_still_valid", {31'd0, valid16}, 32'd1);
    applyStimulus(1'b0, 1'b0, 1'b1);
    checkOutput("bp_after_accept", {31'd0, valid16}, 32'd0);
    checkOutput("bp_last_width", {16'd0, width16}, 32'd5);

    // Fall in IDLE ignored; second rise restarts the count
    applyStimulus(1'b0, 1'b1, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b1);
    checkOutput("idle_fall_valid", {31'd0, valid16}, 32'd0);
    applyStimulus(1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0, 1'b1);
    applyStimulus(1'b1, 1'b0, 1'b1);
    checkOutput("restart_valid", {31'd0, valid16}, 32'd0);
    for (int i = 0; i < 5; i++) applyStimulus(1'b0, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b1, 1'b1);
    checkOutput("restart_width", {16'd0, width16}, 32'd6);
    checkOutput("restart_valid2", {31'd0, valid16}, 32'd1);
    applyStimulus(1'b0, 1'b0, 1'b1);
    checkOutput("restart_single", {31'd0, valid16}, 32'd0);

    // Asynchronous reset mid-measurement with a result held
    runPulse(2, 1'b0);
    checkOutput("mr_held", {16'd0, width16}, 32'd2);
    applyStimulus(1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0);
    #2;
    reset = 1'b0;
    #1;
    checkOutput("mr_valid", {31'd0, valid16}, 32'd0);
    checkOutput("mr_width", {16'd0, width16}, 32'd0);
    checkOutput("mr_ovf",   {31'd0, ovf16},   32'd0);
    checkOutput("mr_drop",  {31'd0, drop16},  32'd0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    applyStimulus(1'b0, 1'b1, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b1);
    checkOutput("mr_fall_ignored", {31'd0, valid16}, 32'd0);
    checkOutput("mr_fall_width",   {16'd0, width16}, 32'd0);

    // Capture of B in the same cycle A is accepted: no gap, no drop
    runPulse(3, 1'b0);
    checkOutput("ab_a_width", {16'd0, width16}, 32'd3);
    applyStimulus(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("ab_a_held", {31'd0, valid16}, 32'd1);
    applyStimulus(1'b0, 1'b1, 1'b1);
    checkOutput("ab_valid", {31'd0, valid16}, 32'd1);
    checkOutput("ab_b_width", {16'd0, width16}, 32'd4);
    checkOutput("ab_nodrop", {31'd0, drop16}, 32'd0);
    applyStimulus(1'b0, 1'b0, 1'b1);
    checkOutput("ab_done", {31'd0, valid16}, 32'd0);
    checkOutput("ab_nodrop2", {31'd0, drop16}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
    $finish;
  end

endmodule
